pingpong_frame_buffer: RTL and testbench
========================================

PINGPONG_FRAME_BUFFER -- requirements
Module: pingpong_frame_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default 19, read-offset width; ADDR_WIDTH >= clog2(IMG_WIDTH*IMG_HEIGHT).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_valid, input, 1, camera pixel strobe.
REQ-008 SHALL have port wr_sof, input, 1, qualifies the wr_valid pixel as the first pixel of a frame.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH, camera pixel.
REQ-010 SHALL have port rd_en, input, 1, read request.
REQ-011 SHALL have port rd_addr, input, ADDR_WIDTH, pixel offset within the display bank.
REQ-012 SHALL have port rd_frame_start, input, 1, reader frame boundary and swap opportunity.
REQ-013 SHALL have port rd_data, output, DATA_WIDTH, read pixel.
REQ-014 SHALL have port rd_valid, output, 1, rd_data valid.
REQ-015 SHALL have port disp_valid, output, 1, display bank holds a complete frame.
REQ-016 SHALL have port pending, output, 1, completed frame awaiting swap.
REQ-017 SHALL have port wr_bank, output, 1, bank currently being written.
REQ-018 SHALL have port sof_err, output, 1, one-cycle pulse on a frame restarted mid-write.
REQ-019 SHALL have port drop_cnt, output, 8, frames dropped while pending, saturating.

Function
REQ-020 SHALL hold 2*IMG_WIDTH*IMG_HEIGHT words; physical address = bank*IMG_WIDTH*IMG_HEIGHT + offset; display bank is always ~wr_bank.
REQ-021 SHALL run writer FSM states IDLE, WRITE, PENDING with an internal write offset counter.
REQ-022 IDLE: wr_valid&wr_sof writes pixel at offset 0, offset<=1, ->WRITE; wr_valid without wr_sof ignored.
REQ-023 WRITE: wr_valid&!wr_sof writes at current offset and increments it; wr_valid&wr_sof writes at offset 0, offset<=1, pulses sof_err.
REQ-024 WRITE: write at offset IMG_WIDTH*IMG_HEIGHT-1 ->PENDING, pending<=1 next cycle.
REQ-025 PENDING: writes suppressed; each wr_valid&wr_sof increments drop_cnt, saturating at 255.
REQ-026 Swap SHALL occur on rd_frame_start while pending=1: wr_bank toggles, pending<=0, disp_valid<=1, FSM ->IDLE.
REQ-027 rd_frame_start with pending=0 SHALL have no effect; reader keeps the current display frame.
REQ-028 Swap coincident with wr_valid&wr_sof SHALL write that pixel to offset 0 of the new write bank, FSM ->WRITE, no drop counted.
REQ-029 Reads SHALL have latency 1: rd_valid<=rd_en; rd_data<=mem[display bank, rd_addr].
REQ-030 Reads in the swap cycle SHALL use the pre-swap display bank; new bank from the next cycle.
REQ-031 rd_addr >= IMG_WIDTH*IMG_HEIGHT SHALL return rd_data=0 with rd_valid=1.
REQ-032 rd_data SHALL hold its last value when rd_en=0.
REQ-033 Reads and writes never target the same bank, so no read-during-write hazard exists.

Reset
REQ-034 rst SHALL asynchronously force: FSM IDLE, offset 0, wr_bank 0, pending 0, disp_valid 0, sof_err 0, drop_cnt 0, rd_valid 0, rd_data 0.
REQ-035 Memory contents SHALL NOT be reset; a partial frame at reset is discarded.
REQ-036 First wr_sof after reset deassertion SHALL be accepted normally.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2)
REQ-037 Write pixels 0x10..0x17 with sof on first -> pending=1; rd_frame_start -> wr_bank=1, disp_valid=1; reads at 0..7 return 0x10..0x17 one cycle after rd_en.
REQ-038 Three sof frames while pending -> drop_cnt=3; 260 such frames -> drop_cnt=255.
REQ-039 sof at offset 5 during WRITE -> sof_err pulses one cycle; frame completes only after 8 further pixels.
REQ-040 rd_frame_start with concurrent sof pixel 0xAA while pending -> swap, 0xAA written at offset 0 of new write bank, drop_cnt unchanged.
REQ-041 Read rd_addr=9 -> rd_data=0, rd_valid=1; rst mid-frame -> all outputs at reset values, disp_valid=0.

Source files
------------

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered camera frame store: the writer fills one bank while the reader
// scans the other; a completed frame is swapped in only at a reader frame boundary.
module pingpong_frame_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_frame_start,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  disp_valid,
  output logic                  pending,
  output logic                  wr_bank,
  output logic                  sof_err,
  output logic [7:0]            drop_cnt
);

  localparam int FRAME = IMG_WIDTH * IMG_HEIGHT;
  localparam int PAW   = $clog2(2 * FRAME);
  localparam int OW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [OW-1:0]       LAST_OFF   = OW'(FRAME - 1);
  localparam logic [PAW-1:0]      BANK1_BASE = PAW'(FRAME);
  localparam logic [ADDR_WIDTH:0] FRAME_LIM  = (ADDR_WIDTH + 1)'(FRAME);

  typedef enum logic [1:0] {IDLE, WRITE, PENDING} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         off_q, off_d;
  logic                  we;
  logic [OW-1:0]         woff;
  logic                  wbank_sel;
  logic                  swap;
  logic                  drop_inc;
  logic                  err_d;
  logic [PAW-1:0]        wr_phys;
  logic [PAW-1:0]        rd_phys;
  logic [DATA_WIDTH-1:0] mem [2*FRAME];

  // Both interfaces are plain strobes with no backpressure: wr_valid and rd_en
  // are accepted on every rising edge they are high.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    we        = 1'b0;
    woff      = off_q;
    wbank_sel = wr_bank;
    swap      = 1'b0;
    drop_inc  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_valid && wr_sof) begin
          we      = 1'b1;
          woff    = '0;
          off_d   = OW'(1);
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          we = 1'b1;
          if (wr_sof) begin
            woff  = '0;
            off_d = OW'(1);
            err_d = 1'b1;
          end else begin
            woff  = off_q;
            off_d = off_q + OW'(1);
          end
        end
      end
      PENDING: begin
        if (rd_frame_start) begin
          swap      = 1'b1;
          state_d   = IDLE;
          off_d     = '0;
          wbank_sel = ~wr_bank;
          // A frame starting in the swap cycle lands in the freshly freed bank.
          if (wr_valid && wr_sof) begin
            we      = 1'b1;
            woff    = '0;
            off_d   = OW'(1);
            state_d = WRITE;
          end
        end else if (wr_valid && wr_sof) begin
          drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (we && woff == LAST_OFF) begin
      state_d = PENDING;
      off_d   = '0;
    end
  end

  assign wr_phys = (wbank_sel ? BANK1_BASE : '0) + PAW'(woff);
  assign rd_phys = (wr_bank ? '0 : BANK1_BASE) + PAW'(rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      off_q      <= '0;
      wr_bank    <= 1'b0;
      pending    <= 1'b0;
      disp_valid <= 1'b0;
      sof_err    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      pending <= (state_d == PENDING);
      sof_err <= err_d;
      if (swap) begin
        wr_bank    <= ~wr_bank;
        disp_valid <= 1'b1;
      end
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_phys] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= ({1'b0, rd_addr} < FRAME_LIM) ? mem[rd_phys] : '0;
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed plus randomized bench for pingpong_frame_buffer (4x2 frames), checked
// against a bank/pixel-count reference model held in the bench.
module tb_pingpong_frame_buffer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_sof, rd_en, rd_frame_start;
  logic [7:0] wr_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid, disp_valid, pending, wr_bank, sof_err;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [7:0] mmem   [2][NPIX];
  bit         mknown [2][NPIX];
  int         m_bank, m_fill, m_drop;
  bit         m_pend, m_disp, m_err, m_rv, m_rd_known;
  logic [7:0] m_rd;

  pingpong_frame_buffer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .ADDR_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_frame_start(rd_frame_start),
    .rd_data(rd_data), .rd_valid(rd_valid), .disp_valid(disp_valid),
    .pending(pending), .wr_bank(wr_bank), .sof_err(sof_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bank = 0; m_fill = -1; m_drop = 0;
    m_pend = 0; m_disp = 0; m_err = 0; m_rv = 0;
    m_rd = 8'h00; m_rd_known = 1;
  endtask

  task automatic model_pix(input logic [7:0] d);
    mmem[m_bank][m_fill]   = d;
    mknown[m_bank][m_fill] = 1;
    m_fill++;
    if (m_fill == NPIX) begin
      m_pend = 1;
      m_fill = -1;
    end
  endtask

  task automatic check_all();
    check("wr_bank", 32'(wr_bank), 32'(m_bank));
    check("pending", 32'(pending), 32'(m_pend));
    check("disp_valid", 32'(disp_valid), 32'(m_disp));
    check("sof_err", 32'(sof_err), 32'(m_err));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input bit v, input bit sof, input logic [7:0] d,
                      input bit rfs, input bit re, input logic [4:0] a);
    wr_valid = v; wr_sof = sof; wr_data = d;
    rd_frame_start = rfs; rd_en = re; rd_addr = a;
    @(posedge clk);
    if (re) begin
      m_rv = 1;
      if (int'(a) >= NPIX) begin
        m_rd = 8'h00; m_rd_known = 1;
      end else begin
        m_rd = mmem[1-m_bank][a]; m_rd_known = mknown[1-m_bank][a];
      end
    end else begin
      m_rv = 0;
    end
    m_err = 0;
    if (m_pend) begin
      if (rfs) begin
        m_bank = 1 - m_bank; m_pend = 0; m_disp = 1; m_fill = -1;
        if (v && sof) begin
          m_fill = 0;
          model_pix(d);
        end
      end else if (v && sof && m_drop < 255) begin
        m_drop++;
      end
    end else if (v) begin
      if (sof) begin
        if (m_fill >= 0) m_err = 1;
        m_fill = 0;
        model_pix(d);
      end else if (m_fill >= 0) begin
        model_pix(d);
      end
    end
    #1;
    check_all();
  endtask

  task automatic write_frame(input logic [7:0] base, input bit rnd);
    for (int i = 0; i < NPIX; i++) begin
      logic [7:0] px;
      px = rnd ? 8'($urandom_range(0, 255)) : base + 8'(i);
      step(1'b1, i == 0, px, 1'b0, 1'b0, 5'd0);
    end
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    wr_valid = 0; wr_sof = 0; rd_en = 0; rd_frame_start = 0;
    #1;
    model_reset();
    check_all();
    check("rst_rd_data", 32'(rd_data), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NPIX; i++) begin
        mmem[b][i] = 8'h00; mknown[b][i] = 0;
      end
    rst = 1'b1;
    wr_valid = 0; wr_sof = 0; wr_data = 0; rd_en = 0; rd_addr = 0; rd_frame_start = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // first frame, swap, read it back
    write_frame(8'h10, 1'b0);
    check("f1_pending", 32'(pending), 32'h1);
    step(0, 0, 8'h00, 1, 0, 5'd0);
    check("f1_wr_bank", 32'(wr_bank), 32'h1);
    check("f1_disp_valid", 32'(disp_valid), 32'h1);
    for (int i = 0; i < NPIX; i++) begin
      step(0, 0, 8'h00, 0, 1, 5'(i));
      check("f1_read", 32'(rd_data), 32'h10 + 32'(i));
    end
    step(0, 0, 8'h00, 0, 0, 5'd3);
    check("rd_hold", 32'(rd_data), 32'h17);

    // swap coincident with a start-of-frame pixel
    write_frame(8'h00, 1'b1);
    step(1, 1, 8'hAA, 1, 0, 5'd0);
    check("sofswap_drop", 32'(drop_cnt), 32'h0);
    check("sofswap_bank", 32'(wr_bank), 32'h0);
    for (int i = 1; i < NPIX; i++) step(1, 0, 8'($urandom_range(0, 255)), 0, 0, 5'd0);
    check("sofswap_pending", 32'(pending), 32'h1);
    step(0, 0, 8'h00, 1, 0, 5'd0);
    step(0, 0, 8'h00, 0, 1, 5'd0);
    check("sofswap_read_aa", 32'(rd_data), 32'hAA);

    // dropped frames while pending
    write_frame(8'h40, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom_range(0, 255)), 0, 0, 5'd0);
    check("drop3", 32'(drop_cnt), 32'h3);
    for (int i = 0; i < 257; i++) step(1, 1, 8'($urandom_range(0, 255)), 0, 0, 5'd0);
    check("drop_sat", 32'(drop_cnt), 32'hFF);

    // restarted frame mid-write
    step(0, 0, 8'h00, 1, 0, 5'd0);
    for (int i = 0; i < 5; i++) step(1, i == 0, 8'h60 + 8'(i), 0, 0, 5'd0);
    step(1, 1, 8'h70, 0, 0, 5'd0);
    check("restart_sof_err", 32'(sof_err), 32'h1);
    for (int i = 1; i < NPIX - 1; i++) step(1, 0, 8'h70 + 8'(i), 0, 0, 5'd0);
    check("restart_sof_err_clr", 32'(sof_err), 32'h0);
    check("restart_not_done", 32'(pending), 32'h0);
    step(1, 0, 8'h77, 0, 0, 5'd0);
    check("restart_done", 32'(pending), 32'h1);

    // out-of-range read
    step(0, 0, 8'h00, 0, 1, 5'd9);
    check("oor_data", 32'(rd_data), 32'h0);
    check("oor_valid", 32'(rd_valid), 32'h1);

    // reset in the middle of a frame, then a normal frame afterwards
    step(0, 0, 8'h00, 1, 0, 5'd0);
    for (int i = 0; i < 3; i++) step(1, i == 0, 8'h80 + 8'(i), 0, 0, 5'd0);
    do_reset();
    check("post_rst_disp", 32'(disp_valid), 32'h0);
    write_frame(8'h90, 1'b0);
    check("post_rst_pending", 32'(pending), 32'h1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit v, sof, rfs, re;
      v   = 1'($urandom_range(0, 1));
      sof = ($urandom_range(0, 9) == 0);
      rfs = ($urandom_range(0, 14) == 0);
      re  = 1'($urandom_range(0, 1));
      step(v, sof, 8'($urandom_range(0, 255)), rfs, re, 5'($urandom_range(0, 10)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
